time_set_ctrl: RTL
==================

// Module: time_set_ctrl
// PURPOSE
//  Button-driven time-setting controller for the hh:mm clock datapath.
//  - Debounces mode/up/down buttons and sequences RUN -> SET_HOUR -> SET_MIN -> RUN.
//  - While setting: gates the timer, edits shadow BCD digits and drives the blink mask for the 7-seg driver.
//  - On exit: issues a one-cycle load of the edited time into the timer.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000   consecutive stable cycles required to accept a button level change
//  BLINK_CYCLES     25_000_000  cycles per blink half-period of the digits being edited
//  REPEAT_DELAY     50_000_000  hold cycles before first auto-repeat (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD    10_000_000  cycles between auto-repeat pulses (AUTO_REPEAT_EN only)
// PORTS
//  clk             in   1  system clock
//  reset_n         in   1  asynchronous, active-low reset
//  btn_mode        in   1  raw mode button, active-high, asynchronous
//  btn_up          in   1  raw increment button, active-high, asynchronous
//  btn_down        in   1  raw decrement button, active-high, asynchronous
//  cur_min_ones    in   4  current timer digit, BCD (likewise cur_min_tens, cur_hour_ones, cur_hour_tens)
//  run_en          out  1  1 = timer counts; 0 = timer frozen
//  load            out  1  one-cycle pulse: timer loads set_* digits
//  set_min_ones    out  4  shadow digit, BCD (likewise set_min_tens, set_hour_ones, set_hour_tens)
//  digit_blank     out  4  per-digit blank: [0]=min_ones [1]=min_tens [2]=hour_ones [3]=hour_tens
//  mode            out  2  state: 0=RUN 1=SET_HOUR 2=SET_MIN
// BEHAVIOUR
//  Reset (async assert, sync deassert inside block):
//  - mode=RUN, run_en=1, load=0, set_*=0, digit_blank=0, blink phase=0, debouncers idle/released.
//  Button conditioning (per button):
//  - 2-FF synchronizer.
//  - Accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the opposite synced value; counter clears on any bounce.
//  - Press pulse is one cycle on accepted 0->1. Release generates nothing.
//  - Latency from clean raw edge to pulse: DEBOUNCE_CYCLES+3 cycles.
//  FSM (advances on mode pulse only):
//  - RUN->SET_HOUR: set_* <= cur_* in the same edge; run_en=0 from the next cycle.
//  - SET_HOUR->SET_MIN: no side effects.
//  - SET_MIN->RUN: load=1 for exactly the first RUN cycle, with set_* stable; run_en=1 the cycle after load.
//  Edits (pulse in SET_HOUR affects hours, in SET_MIN affects minutes; ignored in RUN):
//  - Minutes: up 59->00, down 00->59, otherwise +/-1 with BCD ones/tens carry/borrow.
//  - Hours: up 23->00, down 00->23, otherwise +/-1 BCD. No carry between fields.
//  - set_* values are always legal BCD in range.
//  Simultaneous events:
//  - mode pulse with up/down in the same cycle: mode wins, edit dropped.
//  - up and down pulses in the same cycle: both dropped.
//  Blink:
//  - Free-running counter toggles the phase every BLINK_CYCLES.
//  - Edited pair blanked while phase=1: SET_HOUR -> 4'b1100, SET_MIN -> 4'b0011; RUN -> 4'b0000.
//  - Any accepted edit or mode change clears the counter and phase, so the new value shows immediately.
//  Reset mid-set:
//  - Returns to RUN with no load pulse; edited value is discarded and set_*=0.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//  - up/down held (accepted level 1) in a set state for REPEAT_DELAY cycles emits an extra edit pulse.
//  - Then one extra pulse every REPEAT_PERIOD while held. Timers clear on release or state change.
//  - Repeat pulses obey the same simultaneity rules.
//  AUTO_REPEAT_EN undefined:
//  - Exactly one edit per press; repeat logic and parameters unused.
// TESTING (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
//  - Reset released, no buttons -> mode=0, run_en=1, load=0, digit_blank=0, set_*=0.
//  - cur=12:34, mode press -> SET_HOUR, set=12:34, run_en=0; 3 up presses -> 15:34; mode, mode -> load pulse with 15:34, run_en=1 next cycle.
//  - SET_MIN at 59, up -> 00, hours unchanged; down -> 59; SET_HOUR at 23 up -> 00, 00 down -> 23.
//  - btn_up bouncing 1-0-1 at 2-cycle intervals then stable 1 -> exactly one edit, 7 cycles after the stable edge.
//  - Mode+up pulses same cycle in SET_HOUR -> SET_MIN, hours unchanged; reset asserted in SET_MIN -> RUN, no load.
//  - SET_HOUR idle -> digit_blank alternates 0000/1100 every 8 cycles; with AUTO_REPEAT_EN, hold up 40 cycles -> 1+1+4 edits.

Source files
------------

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven hh:mm time-setting controller
//
// Purpose: debounces mode/up/down buttons and sequences RUN -> SET_HOUR ->
// SET_MIN -> RUN. While setting, it freezes the timer, edits shadow BCD digits
// and blinks the digit pair being edited. On exit it loads the timer for one cycle.
//
// Ports:
//   clk                     system clock
//   reset_n                 asynchronous active-low reset (deasserted internally on clk)
//   btn_mode/btn_up/btn_down raw active-high asynchronous buttons
//   cur_{min,hour}_{ones,tens} current timer digits, BCD
//   run_en                  1 = timer counts, 0 = frozen
//   load                    one-cycle pulse: timer loads set_* digits
//   set_{min,hour}_{ones,tens} shadow digits, BCD
//   digit_blank             [0]=min_ones [1]=min_tens [2]=hour_ones [3]=hour_tens
//   mode                    0=RUN 1=SET_HOUR 2=SET_MIN
//
// Optional feature: define AUTO_REPEAT_EN for held-button auto-repeat edits.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 25_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] cur_min_ones,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_hour_ones,
  input  logic [3:0] cur_hour_tens,
  output logic       run_en,
  output logic       load,
  output logic [3:0] set_min_ones,
  output logic [3:0] set_min_tens,
  output logic [3:0] set_hour_ones,
  output logic [3:0] set_hour_tens,
  output logic [3:0] digit_blank,
  output logic [1:0] mode
);

  // One width for every timer so all terminal-count compares share a type.
  localparam int MAX_A   = (DEBOUNCE_CYCLES > BLINK_CYCLES) ? DEBOUNCE_CYCLES : BLINK_CYCLES;
  localparam int MAX_B   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_SET_HOUR = 2'd1, S_SET_MIN = 2'd2} state_t;

  // Reset: asserts asynchronously, releases after two clk edges.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Button conditioning, index 0=mode 1=up 2=down.
  logic [2:0]       w_raw;
  logic [2:0]       r_sync1, r_sync2, r_level, r_pulse;
  logic [CNT_W-1:0] r_db_cnt [3];
  assign w_raw = {btn_down, btn_up, btn_mode};

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_pulse <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        r_pulse[i] <= 1'b0;
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;                      // any bounce restarts the count
        end else if (r_db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_level[i]  <= r_sync2[i];
          r_db_cnt[i] <= '0;
          r_pulse[i]  <= r_sync2[i];              // press only; release is silent
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  state_t     r_state, w_state_next;
  logic [3:0] r_mo, r_mt, r_ho, r_ht;
  logic [3:0] w_mo, w_mt, w_ho, w_ht;
  logic       r_load, r_run_en, w_load_next, w_run_en_next;
  logic       w_mode_ev, w_inc, w_dec, w_rep_up, w_rep_dn, w_blink_clr;

`ifdef AUTO_REPEAT_EN
  // One repeat timer serves whichever of up/down is held alone; holding both
  // would produce dropped edits anyway.
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_rep_armed;
  logic             w_held, w_rep_fire;
  assign w_held     = (r_state != S_RUN) && (r_level[1] ^ r_level[2]);
  assign w_rep_fire = w_held && !w_mode_ev &&
                      (r_rep_cnt == (r_rep_armed ? CNT_W'(REPEAT_PERIOD - 1)
                                                 : CNT_W'(REPEAT_DELAY - 1)));
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (!w_held || w_mode_ev) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b1;
    end else begin
      r_rep_cnt   <= r_rep_cnt + CNT_W'(1);
    end
  end
  assign w_rep_up = w_rep_fire & r_level[1];
  assign w_rep_dn = w_rep_fire & r_level[2];
`else
  assign w_rep_up = 1'b0;
  assign w_rep_dn = 1'b0;
`endif

  // Mode beats edits; up and down together cancel.
  assign w_mode_ev = r_pulse[0];
  assign w_inc     = (r_pulse[1] | w_rep_up) & ~(r_pulse[2] | w_rep_dn) & ~w_mode_ev;
  assign w_dec     = (r_pulse[2] | w_rep_dn) & ~(r_pulse[1] | w_rep_up) & ~w_mode_ev;

  always_comb begin
    w_state_next = r_state;
    w_mo = r_mo;
    w_mt = r_mt;
    w_ho = r_ho;
    w_ht = r_ht;
    w_load_next = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mode_ev) begin
          w_state_next = S_SET_HOUR;
          w_mo = cur_min_ones;
          w_mt = cur_min_tens;
          w_ho = cur_hour_ones;
          w_ht = cur_hour_tens;
        end
      end
      S_SET_HOUR: begin
        if (w_mode_ev) begin
          w_state_next = S_SET_MIN;
        end else if (w_inc) begin
          if (r_ht == 4'd2 && r_ho == 4'd3) begin w_ht = 4'd0; w_ho = 4'd0; end
          else if (r_ho == 4'd9)            begin w_ho = 4'd0; w_ht = r_ht + 4'd1; end
          else                                    w_ho = r_ho + 4'd1;
        end else if (w_dec) begin
          if (r_ht == 4'd0 && r_ho == 4'd0) begin w_ht = 4'd2; w_ho = 4'd3; end
          else if (r_ho == 4'd0)            begin w_ho = 4'd9; w_ht = r_ht - 4'd1; end
          else                                    w_ho = r_ho - 4'd1;
        end
      end
      S_SET_MIN: begin
        if (w_mode_ev) begin
          w_state_next = S_RUN;
          w_load_next  = 1'b1;
        end else if (w_inc) begin
          if (r_mo == 4'd9) begin
            w_mo = 4'd0;
            w_mt = (r_mt == 4'd5) ? 4'd0 : r_mt + 4'd1;
          end else begin
            w_mo = r_mo + 4'd1;
          end
        end else if (w_dec) begin
          if (r_mo == 4'd0) begin
            w_mo = 4'd9;
            w_mt = (r_mt == 4'd0) ? 4'd5 : r_mt - 4'd1;
          end else begin
            w_mo = r_mo - 4'd1;
          end
        end
      end
      default: w_state_next = S_RUN;
    endcase
    // The timer restarts only after the load cycle has been consumed.
    w_run_en_next = (w_state_next == S_RUN) && !w_load_next;
    w_blink_clr   = w_mode_ev | ((r_state != S_RUN) & (w_inc | w_dec));
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= S_RUN;
      r_mo     <= '0;
      r_mt     <= '0;
      r_ho     <= '0;
      r_ht     <= '0;
      r_load   <= 1'b0;
      r_run_en <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_mo     <= w_mo;
      r_mt     <= w_mt;
      r_ho     <= w_ho;
      r_ht     <= w_ht;
      r_load   <= w_load_next;
      r_run_en <= w_run_en_next;
    end
  end

  // Blink phase; clearing on any accepted change shows the new value at once.
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_phase;
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_blink_clr) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == CNT_W'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    digit_blank = 4'b0000;
    if (r_phase) begin
      if (r_state == S_SET_HOUR)     digit_blank = 4'b1100;
      else if (r_state == S_SET_MIN) digit_blank = 4'b0011;
    end
  end

  assign mode          = r_state;
  assign run_en        = r_run_en;
  assign load          = r_load;
  assign set_min_ones  = r_mo;
  assign set_min_tens  = r_mt;
  assign set_hour_ones = r_ho;
  assign set_hour_tens = r_ht;

endmodule
